// File: rtl/paddle_pkg.sv
// rtl/paddle_pkg.sv - shared types, widths and helpers for the paddle generator
//
// Purpose : common declarations imported by paddle_gen and paddle_array.
// Contents: POS_W/COL_W/SEG_W width constants, paddle FSM state type,
//           clamp_top() helper that keeps a paddle fully inside the visible area.
package paddle_pkg;

  localparam int POS_W = 8;   // paddle top line width
  localparam int COL_W = 9;   // pixel column / line number width
  localparam int SEG_W = 3;   // segment code width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } pad_state_t;

  // Returns min(vpos, max_top). When the clamp bites, max_top is below vpos
  // and therefore fits in POS_W bits.
  function automatic logic [9:0] clamp_top(input logic [POS_W-1:0] vpos,
                                           input logic [9:0]       max_top);
    logic [9:0] v;
    v = {2'b00, vpos};
    return (v > max_top) ? max_top : v;
  endfunction

endpackage

// File: rtl/paddle_gen.sv
// rtl/paddle_gen.sv - one paddle: shadow top latch, line FSM, segment code, window
//
// Purpose : generates a single vertical paddle bar. The top line is latched at
//           frame start, a small FSM tracks the lines the paddle covers and a
//           line counter yields the 3-bit segment code used for ball angle.
//           All outputs are registered, lagging hcount/vcount by one cycle.
// Optional: PADDLE_SHRINK_EN adds i_shrink; when high at frame start that
//           frame uses half the paddle height for clamp, length and segments.
// Ports   :
//   i_clk, i_reset        pixel clock, asynchronous active-high reset
//   i_line_stb            one-cycle pulse at the start of each line
//   i_frame_stb           one-cycle pulse at the start of line 0
//   i_hcount, i_vcount    current pixel column / line
//   i_attract_n           low blanks o_pad only
//   i_vpos, i_hpos        paddle top line / left column
//   i_shrink              (PADDLE_SHRINK_EN only) half-height request
//   o_pad                 paddle video bit
//   o_seg                 segment code 0..7, top to bottom, 0 when inactive
//   o_vactive             paddle covers the current line
module paddle_gen
  import paddle_pkg::*;
#(
  parameter int PAD_HEIGHT    = 16,
  parameter int PAD_WIDTH     = 4,
  parameter int VISIBLE_LINES = 256
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_line_stb,
  input  logic             i_frame_stb,
  input  logic [COL_W-1:0] i_hcount,
  input  logic [COL_W-1:0] i_vcount,
  input  logic             i_attract_n,
  input  logic [POS_W-1:0] i_vpos,
  input  logic [COL_W-1:0] i_hpos,
`ifdef PADDLE_SHRINK_EN
  input  logic             i_shrink,
`endif
  output logic             o_pad,
  output logic [SEG_W-1:0] o_seg,
  output logic             o_vactive
);

  localparam int               CNT_W        = $clog2(PAD_HEIGHT);
  localparam int               HALF_HEIGHT  = PAD_HEIGHT / 2;
  localparam logic [9:0]       MAX_TOP_FULL = 10'(VISIBLE_LINES - PAD_HEIGHT);
  localparam logic [9:0]       MAX_TOP_HALF = 10'(VISIBLE_LINES - HALF_HEIGHT);
  localparam logic [CNT_W-1:0] LAST_FULL    = CNT_W'(PAD_HEIGHT - 1);
  localparam logic [CNT_W-1:0] LAST_HALF    = CNT_W'(HALF_HEIGHT - 1);

  pad_state_t       r_state;
  logic [POS_W-1:0] r_top;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;   // a top has been latched since reset
  logic             r_pad;
  logic [SEG_W-1:0] r_seg;
  logic             r_vact;

  pad_state_t       w_state_next;
  logic [POS_W-1:0] w_top_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_valid_next;
  logic             w_shrink_in;
  logic             w_shrunk_cur;
  logic             w_shrunk_next;
  logic [9:0]       w_max_top;
  logic [POS_W-1:0] w_top_clamped;
  logic [CNT_W-1:0] w_last_cnt;
  logic [9:0]       w_win_lo;
  logic [9:0]       w_win_hi;
  logic [9:0]       w_col;
  logic             w_hwin;
  logic             w_active_next;
  logic [SEG_W-1:0] w_seg_full;
  logic [SEG_W-1:0] w_seg_half;
  logic [SEG_W-1:0] w_seg_next;

`ifdef PADDLE_SHRINK_EN
  logic r_shrunk;

  assign w_shrink_in  = i_shrink;
  assign w_shrunk_cur = r_shrunk;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shrunk <= 1'b0;
    end else begin
      r_shrunk <= w_shrunk_next;
    end
  end
`else
  assign w_shrink_in  = 1'b0;
  assign w_shrunk_cur = 1'b0;
`endif

  // The shrink choice is sampled together with the top at frame start.
  assign w_shrunk_next = i_frame_stb ? w_shrink_in : w_shrunk_cur;

  assign w_max_top     = w_shrink_in ? MAX_TOP_HALF : MAX_TOP_FULL;
  assign w_top_clamped = POS_W'(clamp_top(i_vpos, w_max_top));
  assign w_last_cnt    = w_shrunk_cur ? LAST_HALF : LAST_FULL;

  // 10-bit window bounds so a paddle near column 511 never wraps to column 0.
  assign w_col    = {1'b0, i_hcount};
  assign w_win_lo = {1'b0, i_hpos};
  assign w_win_hi = w_win_lo + 10'(PAD_WIDTH);
  assign w_hwin   = (w_col >= w_win_lo) && (w_col < w_win_hi);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_top   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_top   <= w_top_next;
      r_cnt   <= w_cnt_next;
      r_valid <= w_valid_next;
    end
  end

  // frame_stb restarts the paddle from IDLE and immediately tests the newly
  // latched top, so a paddle at top 0 is active on line 0.
  always_comb begin
    w_state_next = r_state;
    w_top_next   = r_top;
    w_cnt_next   = r_cnt;
    w_valid_next = r_valid;
    if (i_frame_stb) begin
      w_top_next   = w_top_clamped;
      w_valid_next = 1'b1;
      w_cnt_next   = '0;
      w_state_next = (i_vcount == {1'b0, w_top_clamped}) ? ACTIVE : IDLE;
    end else if (i_line_stb) begin
      case (r_state)
        IDLE: begin
          if (r_valid && (i_vcount == {1'b0, r_top})) begin
            w_state_next = ACTIVE;
            w_cnt_next   = '0;
          end
        end
        ACTIVE: begin
          if (r_cnt == w_last_cnt) begin
            w_state_next = DONE;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          w_state_next = DONE;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // Outputs follow the state being entered this cycle, so the first pixel of
  // a line (the line_stb cycle itself) is already covered.
  assign w_active_next = (w_state_next == ACTIVE);
  assign w_seg_full    = SEG_W'((32'(w_cnt_next) * 8) / PAD_HEIGHT);
  assign w_seg_half    = SEG_W'((32'(w_cnt_next) * 8) / HALF_HEIGHT);
  assign w_seg_next    = w_shrunk_next ? w_seg_half : w_seg_full;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pad  <= 1'b0;
      r_seg  <= '0;
      r_vact <= 1'b0;
    end else begin
      r_vact <= w_active_next;
      r_seg  <= w_active_next ? w_seg_next : '0;
      r_pad  <= w_active_next & w_hwin & i_attract_n;
    end
  end

  assign o_pad     = r_pad;
  assign o_seg     = r_seg;
  assign o_vactive = r_vact;

endmodule

// File: rtl/paddle_array.sv
// rtl/paddle_array.sv - NUM_PADDLES independent vertical paddle bars for the video path
//
// Purpose : instantiates one paddle_gen per paddle; paddles are fully
//           independent and overlapping paddles have no priority.
// Optional: PADDLE_SHRINK_EN adds the shrink input shared by all paddles.
// Ports   :
//   clk7_159              pixel clock
//   reset                 asynchronous active-high reset
//   line_stb, frame_stb   line / frame start pulses (frame_stb coincides with line_stb)
//   hcount, vcount        current pixel column / line
//   attract_n             low blanks every pad bit
//   pad_vpos              8 bits per paddle, paddle k in [8k+7:8k]
//   pad_hpos              9 bits per paddle, packed the same way
//   shrink                (PADDLE_SHRINK_EN only) half-height for the next frame
//   pad                   video bit per paddle
//   pad_seg               {d,c,b} segment code per paddle, 3 bits each
//   pad_vactive           paddle covers the current line
module paddle_array
  import paddle_pkg::*;
#(
  parameter int NUM_PADDLES   = 2,
  parameter int PAD_HEIGHT    = 16,
  parameter int PAD_WIDTH     = 4,
  parameter int VISIBLE_LINES = 256
) (
  input  logic                         clk7_159,
  input  logic                         reset,
  input  logic                         line_stb,
  input  logic                         frame_stb,
  input  logic [COL_W-1:0]             hcount,
  input  logic [COL_W-1:0]             vcount,
  input  logic                         attract_n,
  input  logic [POS_W*NUM_PADDLES-1:0] pad_vpos,
  input  logic [COL_W*NUM_PADDLES-1:0] pad_hpos,
`ifdef PADDLE_SHRINK_EN
  input  logic                         shrink,
`endif
  output logic [NUM_PADDLES-1:0]       pad,
  output logic [SEG_W*NUM_PADDLES-1:0] pad_seg,
  output logic [NUM_PADDLES-1:0]       pad_vactive
);

  for (genvar k = 0; k < NUM_PADDLES; k++) begin : g_pad
    paddle_gen #(
      .PAD_HEIGHT    (PAD_HEIGHT),
      .PAD_WIDTH     (PAD_WIDTH),
      .VISIBLE_LINES (VISIBLE_LINES)
    ) u_gen (
      .i_clk       (clk7_159),
      .i_reset     (reset),
      .i_line_stb  (line_stb),
      .i_frame_stb (frame_stb),
      .i_hcount    (hcount),
      .i_vcount    (vcount),
      .i_attract_n (attract_n),
      .i_vpos      (pad_vpos[POS_W*k +: POS_W]),
      .i_hpos      (pad_hpos[COL_W*k +: COL_W]),
`ifdef PADDLE_SHRINK_EN
      .i_shrink    (shrink),
`endif
      .o_pad       (pad[k]),
      .o_seg       (pad_seg[SEG_W*k +: SEG_W]),
      .o_vactive   (pad_vactive[k])
    );
  end

endmodule

// File: tb/tb_paddle_array.sv
// tb/tb_paddle_array.sv - directed table-driven bench for paddle_array
module tb_paddle_array;

  localparam int NP    = 2;
  localparam int HLEN  = 40;   // pixels per simulated line
  localparam int MAXL  = 258;  // lines recorded per frame

  localparam logic [63:0] M0  = 64'h0000_000F_0000_0000;  // columns 32..35
  localparam logic [63:0] M8  = 64'h0000_0000_0000_0F00;  // columns 8..11
  localparam logic [63:0] M34 = 64'h0000_003C_0000_0000;  // columns 34..37
  localparam logic [63:0] MH0 = 64'h0000_0000_0000_000F;  // columns 0..3

  logic        clk = 1'b0;
  logic        reset;
  logic        line_stb;
  logic        frame_stb;
  logic [8:0]  hcount;
  logic [8:0]  vcount;
  logic        attract_n;
  logic [15:0] pad_vpos;
  logic [17:0] pad_hpos;
`ifdef PADDLE_SHRINK_EN
  logic        shrink;
`endif
  logic [1:0]  pad;
  logic [5:0]  pad_seg;
  logic [1:0]  pad_vactive;

  always #5 clk = ~clk;

  paddle_array #(
    .NUM_PADDLES   (NP),
    .PAD_HEIGHT    (16),
    .PAD_WIDTH     (4),
    .VISIBLE_LINES (256)
  ) dut (
    .clk7_159    (clk),
    .reset       (reset),
    .line_stb    (line_stb),
    .frame_stb   (frame_stb),
    .hcount      (hcount),
    .vcount      (vcount),
    .attract_n   (attract_n),
    .pad_vpos    (pad_vpos),
    .pad_hpos    (pad_hpos),
`ifdef PADDLE_SHRINK_EN
    .shrink      (shrink),
`endif
    .pad         (pad),
    .pad_seg     (pad_seg),
    .pad_vactive (pad_vactive)
  );

  typedef struct {
    int          scen;
    int          p;
    int          line;
    bit          vact;
    int          seg;
    logic [63:0] mask;
  } vec_t;

  vec_t        vt[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] rec_mask [0:NP-1][0:MAXL-1];
  int          rec_seg  [0:NP-1][0:MAXL-1];
  bit          rec_vact [0:NP-1][0:MAXL-1];
  int          rst_on   = -1;
  int          rst_off  = -1;
  int          chg_line = -1;
  logic [7:0]  chg_vpos = 8'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic add(input int scen, input int p, input int line,
                     input bit vact, input int seg, input logic [63:0] mask);
    vec_t v;
    v.scen = scen; v.p = p; v.line = line; v.vact = vact; v.seg = seg; v.mask = mask;
    vt.push_back(v);
  endtask

  // One pixel: drive inputs, clock, then record outputs against the pixel
  // that produced them (the registered outputs lag by one cycle).
  task automatic pix(input int h, input int v);
    hcount    = 9'(h);
    vcount    = 9'(v);
    line_stb  = (h == 0);
    frame_stb = (h == 0) && (v == 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < NP; k++) begin
      if (pad[k]) rec_mask[k][v][h] = 1'b1;
      if (h == 20) begin
        rec_seg[k][v]  = int'(pad_seg[3*k +: 3]);
        rec_vact[k][v] = pad_vactive[k];
      end
    end
  endtask

  task automatic run_frame(input int nlines);
    for (int k = 0; k < NP; k++) begin
      for (int l = 0; l < MAXL; l++) begin
        rec_mask[k][l] = '0;
        rec_seg[k][l]  = -1;
        rec_vact[k][l] = 1'b0;
      end
    end
    for (int v = 0; v < nlines; v++) begin
      for (int h = 0; h < HLEN; h++) begin
        if (h == 0) begin
          if (v == rst_on)   reset = 1'b1;
          if (v == rst_off)  reset = 1'b0;
          if (v == chg_line) pad_vpos[7:0] = chg_vpos;
        end
        pix(h, v);
      end
    end
    line_stb  = 1'b0;
    frame_stb = 1'b0;
  endtask

  task automatic apply(input int scen);
    foreach (vt[i]) begin
      if (vt[i].scen == scen) begin
        chk($sformatf("s%0d_p%0d_l%0d_vact", scen, vt[i].p, vt[i].line),
            64'(rec_vact[vt[i].p][vt[i].line]), 64'(vt[i].vact));
        chk($sformatf("s%0d_p%0d_l%0d_seg", scen, vt[i].p, vt[i].line),
            64'(rec_seg[vt[i].p][vt[i].line]), 64'(vt[i].seg));
        chk($sformatf("s%0d_p%0d_l%0d_pad", scen, vt[i].p, vt[i].line),
            rec_mask[vt[i].p][vt[i].line], vt[i].mask);
      end
    end
  endtask

  initial begin
    logic [63:0] any_pad;

    // scen 1: p0 top 100 col 32, p1 top 60 col 8
    add(1,0, 99,0,0,0);  add(1,0,100,1,0,M0); add(1,0,101,1,0,M0); add(1,0,102,1,1,M0);
    add(1,0,107,1,3,M0); add(1,0,114,1,7,M0); add(1,0,115,1,7,M0); add(1,0,116,0,0,0);
    add(1,1, 59,0,0,0);  add(1,1, 60,1,0,M8); add(1,1, 75,1,7,M8); add(1,1, 76,0,0,0);
    // scen 2: p0 250 clamps to 240, p1 top 0 col 0
    add(2,0,239,0,0,0);  add(2,0,240,1,0,M0); add(2,0,247,1,3,M0); add(2,0,255,1,7,M0);
    add(2,0,256,0,0,0);  add(2,0,257,0,0,0);
    add(2,1,  0,1,0,MH0); add(2,1, 15,1,7,MH0); add(2,1, 16,0,0,0);
    // scen 3: vpos 100 -> 20 at line 105; scen 4: following frame
    add(3,0, 20,0,0,0);  add(3,0,100,1,0,M0); add(3,0,115,1,7,M0); add(3,0,116,0,0,0);
    add(4,0, 19,0,0,0);  add(4,0, 20,1,0,M0); add(4,0, 35,1,7,M0); add(4,0, 36,0,0,0);
    add(4,0,100,0,0,0);
    // scen 5: attract mode
    add(5,0,100,1,0,0);  add(5,0,108,1,4,0);  add(5,0,115,1,7,0);  add(5,0,116,0,0,0);
    add(5,1, 60,1,0,0);
    // scen 6: reset lines 108..109; scen 7: following frame
    add(6,0,107,1,3,M0); add(6,0,108,0,0,0);  add(6,0,109,0,0,0);  add(6,0,110,0,0,0);
    add(6,0,112,0,0,0);  add(6,0,115,0,0,0);  add(6,1, 60,1,0,M8);
    add(7,0,100,1,0,M0); add(7,0,115,1,7,M0); add(7,1, 60,1,0,M8);
    // scen 8: overlapping paddles
    add(8,0,100,1,0,M0); add(8,0,104,1,2,M0); add(8,0,115,1,7,M0);
    add(8,1,103,0,0,0);  add(8,1,104,1,0,M34); add(8,1,110,1,3,M34);
    add(8,1,116,1,6,M34); add(8,1,119,1,7,M34);
`ifdef PADDLE_SHRINK_EN
    // scen 9: shrink, p0 250 clamps to 248, p1 top 0
    add(9,0,247,0,0,0);  add(9,0,248,1,0,M0); add(9,0,249,1,1,M0); add(9,0,255,1,7,M0);
    add(9,0,256,0,0,0);
    add(9,1,  0,1,0,MH0); add(9,1, 7,1,7,MH0); add(9,1, 8,0,0,0);
`endif

    reset = 1'b1; line_stb = 1'b0; frame_stb = 1'b0; hcount = '0; vcount = '0;
    attract_n = 1'b1; pad_vpos = '0; pad_hpos = '0;
`ifdef PADDLE_SHRINK_EN
    shrink = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pad",  64'(pad), 64'd0);
    chk("reset_seg",  64'(pad_seg), 64'd0);
    chk("reset_vact", 64'(pad_vactive), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // A line strobe on line 0 without frame_stb must not start a paddle.
    line_stb = 1'b1;
    @(posedge clk);
    #1;
    line_stb = 1'b0;
    @(posedge clk);
    #1;
    chk("no_frame_vact", 64'(pad_vactive), 64'd0);

    pad_vpos = {8'd60, 8'd100};
    pad_hpos = {9'd8, 9'd32};
    run_frame(120);
    apply(1);
    for (int i = 0; i < 16; i++)
      chk($sformatf("seg_seq_l%0d", 100 + i), 64'(rec_seg[0][100 + i]), 64'((i * 8) / 16));

    pad_vpos = {8'd0, 8'd250};
    pad_hpos = {9'd0, 9'd32};
    run_frame(MAXL);
    apply(2);

    pad_vpos = {8'd60, 8'd100};
    pad_hpos = {9'd8, 9'd32};
    chg_line = 105; chg_vpos = 8'd20;
    run_frame(120);
    apply(3);
    chg_line = -1;
    run_frame(120);
    apply(4);

    pad_vpos  = {8'd60, 8'd100};
    attract_n = 1'b0;
    run_frame(120);
    apply(5);
    any_pad = '0;
    for (int k = 0; k < NP; k++)
      for (int l = 0; l < 120; l++) any_pad |= rec_mask[k][l];
    chk("attract_dark", any_pad, 64'd0);
    attract_n = 1'b1;

    rst_on = 108; rst_off = 110;
    run_frame(120);
    apply(6);
    rst_on = -1; rst_off = -1;
    run_frame(120);
    apply(7);

    pad_vpos = {8'd104, 8'd100};
    pad_hpos = {9'd34, 9'd32};
    run_frame(120);
    apply(8);

`ifdef PADDLE_SHRINK_EN
    pad_vpos = {8'd0, 8'd250};
    pad_hpos = {9'd0, 9'd32};
    shrink   = 1'b1;
    run_frame(MAXL);
    apply(9);
    shrink   = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
